// File: rtl/mult_control.sv
// Sequencer for the signed shift-add multiplier: one CLEAR, WIDTH add/shift
// pairs and a HOLD per Run assertion; LoadClr is honoured only while idle.
module mult_control #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic LoadClr,
  input  logic M,
  output logic LoadB,
  output logic ClearXA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  // state | meaning
  // IDLE  | waiting; LoadClr loads B and clears X/A, Run starts a multiply
  // CLEAR | clear X/A so every run starts from zero, reset iteration count
  // ADD   | add (or subtract on the sign bit) SW when M=1
  // SHIFT | arithmetic right shift of {X,A,B}, advance iteration
  // HOLD  | result held on the displays until Run is released
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    LoadB      = 1'b0;
    ClearXA    = 1'b0;
    Add        = 1'b0;
    Sub        = 1'b0;
    Shift      = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      IDLE: begin
        // LoadClr wins over Run so a held load never races a start
        if (LoadClr) begin
          LoadB   = 1'b1;
          ClearXA = 1'b1;
        end else if (Run) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        ClearXA    = 1'b1;
        Busy       = 1'b1;
        cnt_next   = '0;
        state_next = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // the last multiplier bit carries negative weight in two's complement
        if (M) begin
          if (last) Sub = 1'b1;
          else      Add = 1'b1;
        end
        state_next = SHIFT;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        if (last) begin
          state_next = HOLD;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          state_next = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control: stimulus pushes expected per-cycle strobes
// and products; a negedge monitor pops and compares against the DUT.
module tb_mult_control;

  logic Clk, Reset, Run, LoadClr, M;
  logic LoadB, ClearXA, Add, Sub, Shift, Busy, Done;
  logic [7:0] SW;

  mult_control #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .LoadClr(LoadClr), .M(M),
    .LoadB(LoadB), .ClearXA(ClearXA), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [6:0] LB  = 7'b1000000;
  localparam logic [6:0] CX  = 7'b0100000;
  localparam logic [6:0] AD  = 7'b0010000;
  localparam logic [6:0] SB  = 7'b0001000;
  localparam logic [6:0] SH  = 7'b0000100;
  localparam logic [6:0] BY  = 7'b0000010;
  localparam logic [6:0] DN  = 7'b0000001;
  localparam logic [6:0] ALL = 7'b1111111;

  typedef struct {
    logic [6:0] v;
    logic [6:0] m;
    string      tag;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [15:0] prod_q[$];
  int checks = 0;
  int failures = 0;

  // behavioural datapath: {X,A,B} registers driven by the DUT strobes
  logic [7:0] a_reg, b_reg;
  logic       x_reg;
  logic [8:0] dp_sum;
  logic       s_lb, s_cx, s_ad, s_sb, s_sh;
  logic [7:0] s_sw;

  assign M = b_reg[0];

  always @(negedge Clk) begin
    s_lb = LoadB; s_cx = ClearXA; s_ad = Add; s_sb = Sub; s_sh = Shift; s_sw = SW;
  end

  always @(posedge Clk) begin
    if (s_lb === 1'b1) b_reg <= s_sw;
    if (s_cx === 1'b1) begin a_reg <= 8'h00; x_reg <= 1'b0; end
    if (s_ad === 1'b1) begin
      dp_sum = {a_reg[7], a_reg} + {s_sw[7], s_sw};
      a_reg <= dp_sum[7:0]; x_reg <= dp_sum[8];
    end
    if (s_sb === 1'b1) begin
      dp_sum = {a_reg[7], a_reg} - {s_sw[7], s_sw};
      a_reg <= dp_sum[7:0]; x_reg <= dp_sum[8];
    end
    if (s_sh === 1'b1) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  // monitor
  logic       done_q;
  logic [6:0] out;
  exp_t       ent;
  logic signed [15:0] pexp;
  always @(negedge Clk) begin
    out = {LoadB, ClearXA, Add, Sub, Shift, Busy, Done};
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      checks++;
      if ((out & ent.m) !== (ent.v & ent.m)) begin
        failures++;
        $display("FAIL %s: got %b want %b (mask %b) t=%0t", ent.tag, out, ent.v, ent.m, $time);
      end
    end
    if (Done === 1'b1 && done_q !== 1'b1) begin
      checks++;
      if (prod_q.size() == 0) begin
        failures++;
        $display("FAIL product: unexpected Done, got %h want none", {a_reg, b_reg});
      end else begin
        pexp = prod_q.pop_front();
        if ({a_reg, b_reg} !== pexp) begin
          failures++;
          $display("FAIL product: got %h want %h", {a_reg, b_reg}, pexp);
        end
      end
    end
    done_q = Done;
  end

  task automatic step(input logic r, input logic lc, input logic rst, input logic [7:0] sw,
                      input logic [6:0] e, input logic [6:0] m, input string tag);
    @(posedge Clk);
    #1;
    Run = r; LoadClr = lc; Reset = rst; SW = sw;
    exp_q.push_back('{v: e, m: m, tag: tag});
  endtask

  // One complete multiply: load B, start, WIDTH iterations, hold, release.
  task automatic mult(input logic [7:0] a, input logic [7:0] b, input int hold,
                      input bit collide, input bit noisy);
    logic signed [15:0] p;
    logic r;
    p = $signed(a) * $signed(b);
    step(collide, 1'b1, 1'b0, b, LB | CX, ALL, "load");
    step(1'b1, 1'b0, 1'b0, a, 7'b0, ALL, "start_idle");
    prod_q.push_back(p);
    r = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
    step(r, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, a, CX | BY, ALL, "clear");
    for (int i = 0; i < 8; i++) begin
      r = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(r, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, a,
           BY | (b[i] ? ((i == 7) ? SB : AD) : 7'b0), ALL, "add");
      r = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(r, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, a, SH | BY, ALL, "shift");
    end
    for (int h = 0; h < hold; h++)
      step(1'b1, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, a, DN, ALL, "hold");
    step(1'b0, 1'b0, 1'b0, a, DN, ALL, "hold_exit");
    step(1'b0, 1'b0, 1'b0, a, 7'b0, ALL, "idle_after");
  endtask

  initial begin
    Run = 1'b0; LoadClr = 1'b0; Reset = 1'b1; SW = 8'h00;
    step(1'b0, 1'b0, 1'b1, 8'h00, 7'b0, ALL, "reset");
    step(1'b0, 1'b0, 1'b0, 8'h00, 7'b0, ALL, "reset_out");

    // LoadClr held in IDLE
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 8'hC5, LB | CX, ALL, "loadclr_held");
    step(1'b0, 1'b0, 1'b0, 8'h07, 7'b0, ALL, "idle");

    // reset during ADD with counter=3, then restart
    step(1'b1, 1'b0, 1'b0, 8'h07, 7'b0, ALL, "rst_start");
    step(1'b1, 1'b0, 1'b0, 8'h07, CX | BY, ALL, "rst_clear");
    step(1'b1, 1'b0, 1'b0, 8'h07, BY | AD, ALL, "rst_add0");
    step(1'b1, 1'b0, 1'b0, 8'h07, SH | BY, ALL, "rst_shift0");
    step(1'b1, 1'b0, 1'b0, 8'h07, BY, ALL, "rst_add1");
    step(1'b1, 1'b0, 1'b0, 8'h07, SH | BY, ALL, "rst_shift1");
    step(1'b1, 1'b0, 1'b0, 8'h07, BY | AD, ALL, "rst_add2");
    step(1'b1, 1'b0, 1'b0, 8'h07, SH | BY, ALL, "rst_shift2");
    step(1'b1, 1'b0, 1'b1, 8'h07, BY, ALL, "rst_add3");
    step(1'b1, 1'b0, 1'b0, 8'h07, 7'b0, ALL, "post_reset");
    step(1'b0, 1'b0, 1'b0, 8'h07, CX | BY, ALL, "restart_clear");
    step(1'b0, 1'b0, 1'b1, 8'h07, BY, ~(AD | SB), "restart_add0");
    step(1'b0, 1'b0, 1'b0, 8'h07, 7'b0, ALL, "reset_idle");

    // directed multiplies
    mult(8'h07, 8'hC5, 2, 1'b0, 1'b0);    // 7 * -59 = 0xFE63
    mult(8'hF9, 8'hC5, 0, 1'b0, 1'b0);    // -7 * -59 = 0x019D
    mult(8'h07, 8'h3B, 100, 1'b0, 1'b0);  // 7 * 59, Run held long after Done
    mult(8'h80, 8'h80, 1, 1'b1, 1'b0);    // Run+LoadClr collision, -128 * -128
    mult(8'h7F, 8'h80, 0, 1'b0, 1'b1);
    mult(8'hFF, 8'hFF, 0, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++)
      mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    step(1'b0, 1'b0, 1'b0, 8'h00, 7'b0, ALL, "tail");
    @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (prod_q.size() != 0) begin
      failures++;
      $display("FAIL missing_done: got %0d products pending want 0", prod_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
